// File: rtl/ieeedrv_pkg.sv
// Shared sync codes, header length and parser state encoding for the
// IEEE drive track-stream receiver.
package ieeedrv_pkg;

    localparam logic [7:0] HEADER_SYNC_CODE = 8'h08;
    localparam logic [7:0] DATA_SYNC_CODE   = 8'h07;
    localparam logic [7:0] TEST_SYNC_CODE   = 8'h0F;

    localparam int HDR_LEN = 5;

    typedef enum logic [2:0] {
        P_IDLE,
        P_SYNC,
        P_CODE,
        P_HDR,
        P_DATA,
        P_CHK
    } parseState_t;

endpackage

// File: rtl/ieeedrv_trkparse_if.sv
// Stream inputs and decoded sector results of the track-stream parser.
interface ieeedrv_trkparse_if;

    logic        en;
    logic        sync_rd_n;
    logic        brdy_n;
    logic [7:0]  byte_rd;

    logic        hdr_valid;
    logic        hdr_err;
    logic [7:0]  hdr_sector;
    logic [7:0]  hdr_track;
    logic [15:0] hdr_id;
    logic        data_we;
    logic [7:0]  data_addr;
    logic [7:0]  data_do;
    logic        data_done;
    logic        data_err;
    logic        test_seen;
    logic        abort;
    logic [2:0]  state;

    modport master (
        output en, sync_rd_n, brdy_n, byte_rd,
        input  hdr_valid, hdr_err, hdr_sector, hdr_track, hdr_id,
        input  data_we, data_addr, data_do, data_done, data_err,
        input  test_seen, abort, state
    );

    modport slave (
        input  en, sync_rd_n, brdy_n, byte_rd,
        output hdr_valid, hdr_err, hdr_sector, hdr_track, hdr_id,
        output data_we, data_addr, data_do, data_done, data_err,
        output test_seen, abort, state
    );

endinterface

// File: rtl/ieeedrv_bytestrobe.sv
// Falling-edge detector on brdy_n, gated so that a byte arriving while the
// sync line is low is dropped in favour of the sync.
module ieeedrv_bytestrobe (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       i_brdy_n,
    input  logic       i_sync_rd_n,
    input  logic [7:0] i_byte,
    output logic       o_strobe,
    output logic [7:0] o_byte,
    output logic       o_in_sync
);

    logic r_brdy_l;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_brdy_l <= 1'b1;
        end else begin
            r_brdy_l <= i_brdy_n;
        end
    end

    assign o_in_sync = ~i_sync_rd_n;
    assign o_strobe  = r_brdy_l & ~i_brdy_n & i_sync_rd_n;
    assign o_byte    = i_byte;

endmodule

// File: rtl/ieeedrv_trkparse.sv
// Track-stream parser: classifies sync codes, checks headers, streams data
// blocks to a write port and tracks whether the last good header is still fresh.
module ieeedrv_trkparse
    import ieeedrv_pkg::*;
#(
    parameter int DATA_LEN = 256,
    parameter int MAX_GAP  = 48
) (
    input  logic clk_sys,
    input  logic reset_n,
    ieeedrv_trkparse_if.slave bus
);

    localparam int GAP_W = $clog2(MAX_GAP + 2);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_GAP);
    localparam logic [GAP_W-1:0] GAP_SAT   = GAP_W'(MAX_GAP + 1);
    localparam logic [8:0]       HDR_LAST  = 9'(HDR_LEN - 1);
    localparam logic [8:0]       DATA_LAST = 9'(DATA_LEN - 1);

    function automatic logic [GAP_W-1:0] gap_inc(input logic [GAP_W-1:0] g);
        return (g == GAP_SAT) ? g : g + 1'b1;
    endfunction

    logic       w_strobe;
    logic [7:0] w_byte;
    logic       w_in_sync;

    ieeedrv_bytestrobe u_strobe (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .i_brdy_n    (bus.brdy_n),
        .i_sync_rd_n (bus.sync_rd_n),
        .i_byte      (bus.byte_rd),
        .o_strobe    (w_strobe),
        .o_byte      (w_byte),
        .o_in_sync   (w_in_sync)
    );

    parseState_t r_state, w_state_nxt;
    logic        w_abort, w_test, w_hdr_start, w_data_start;
    logic        w_hdr_byte, w_data_byte, w_chk_byte;
    logic        w_hdr_done, w_hdr_err, w_gap_tick;
    logic [GAP_W-1:0] w_gap_inc;

    logic [8:0]       r_idx;
    logic [7:0]       r_chk;
    logic [7:0]       r_hbuf [HDR_LEN-1];
    logic             r_fresh;
    logic [GAP_W-1:0] r_gap;

    logic        r_hdr_valid_p1, r_hdr_err_p1, r_data_we_p1, r_data_done_p1;
    logic        r_data_err_p1, r_test_seen_p1, r_abort_p1;
    logic [7:0]  r_hdr_sector_p1, r_hdr_track_p1, r_data_addr_p1, r_data_do_p1;
    logic [15:0] r_hdr_id_p1;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= P_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_abort      = 1'b0;
        w_test       = 1'b0;
        w_hdr_start  = 1'b0;
        w_data_start = 1'b0;
        w_hdr_byte   = 1'b0;
        w_data_byte  = 1'b0;
        w_chk_byte   = 1'b0;
        if (!bus.en) begin
            w_state_nxt = P_IDLE;
            w_abort     = (r_state != P_IDLE);
        end else begin
            unique case (r_state)
                P_IDLE: if (w_in_sync) w_state_nxt = P_SYNC;
                P_SYNC: if (!w_in_sync) w_state_nxt = P_CODE;
                P_CODE: begin
                    if (w_in_sync) begin
                        w_state_nxt = P_SYNC;
                    end else if (w_strobe) begin
                        case (w_byte)
                            HEADER_SYNC_CODE: begin w_state_nxt = P_HDR;  w_hdr_start  = 1'b1; end
                            DATA_SYNC_CODE:   begin w_state_nxt = P_DATA; w_data_start = 1'b1; end
                            TEST_SYNC_CODE:   begin w_state_nxt = P_IDLE; w_test       = 1'b1; end
                            default:          begin w_state_nxt = P_IDLE; w_abort      = 1'b1; end
                        endcase
                    end
                end
                P_HDR: begin
                    if (w_in_sync) begin
                        w_state_nxt = P_SYNC;
                        w_abort     = 1'b1;
                    end else if (w_strobe) begin
                        w_hdr_byte = 1'b1;
                        if (r_idx == HDR_LAST) w_state_nxt = P_IDLE;
                    end
                end
                P_DATA: begin
                    if (w_in_sync) begin
                        w_state_nxt = P_SYNC;
                        w_abort     = 1'b1;
                    end else if (w_strobe) begin
                        w_data_byte = 1'b1;
                        if (r_idx == DATA_LAST) w_state_nxt = P_CHK;
                    end
                end
                P_CHK: begin
                    if (w_in_sync) begin
                        w_state_nxt = P_SYNC;
                        w_abort     = 1'b1;
                    end else if (w_strobe) begin
                        w_chk_byte  = 1'b1;
                        w_state_nxt = P_IDLE;
                    end
                end
                default: w_state_nxt = P_IDLE;
            endcase
        end
    end

    assign w_hdr_done = w_hdr_byte && (r_idx == HDR_LAST);
    assign w_hdr_err  = r_hbuf[0] != (r_hbuf[1] ^ r_hbuf[2] ^ r_hbuf[3] ^ w_byte);
    assign w_gap_tick = w_strobe && r_fresh && (r_state != P_DATA) && (r_state != P_CHK);
    assign w_gap_inc  = gap_inc(r_gap);

    // Stage p0 -> p1: strobe-cycle decisions land in the output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_idx           <= '0;
            r_fresh         <= 1'b0;
            r_gap           <= '0;
            r_hdr_valid_p1  <= 1'b0;
            r_hdr_err_p1    <= 1'b0;
            r_hdr_sector_p1 <= '0;
            r_hdr_track_p1  <= '0;
            r_hdr_id_p1     <= '0;
            r_data_we_p1    <= 1'b0;
            r_data_addr_p1  <= '0;
            r_data_do_p1    <= '0;
            r_data_done_p1  <= 1'b0;
            r_data_err_p1   <= 1'b0;
            r_test_seen_p1  <= 1'b0;
            r_abort_p1      <= 1'b0;
        end else begin
            r_hdr_valid_p1 <= w_hdr_done;
            r_data_we_p1   <= w_data_byte;
            r_data_done_p1 <= w_chk_byte;
            r_test_seen_p1 <= w_test;
            r_abort_p1     <= w_abort;

            if (w_hdr_start || w_data_start) begin
                r_idx <= '0;
            end else if (w_hdr_byte || w_data_byte) begin
                r_idx <= r_idx + 9'd1;
            end

            if (w_hdr_done) begin
                r_hdr_err_p1    <= w_hdr_err;
                r_hdr_sector_p1 <= r_hbuf[1];
                r_hdr_track_p1  <= r_hbuf[2];
                r_hdr_id_p1     <= {r_hbuf[3], w_byte};
            end
            if (w_data_byte) begin
                r_data_addr_p1 <= r_idx[7:0];
                r_data_do_p1   <= w_byte;
            end
            if (w_chk_byte) begin
                r_data_err_p1 <= (w_byte != r_chk) || !r_fresh;
            end

            if (w_hdr_done) begin
                r_gap <= '0;
            end else if (w_gap_tick) begin
                r_gap <= w_gap_inc;
            end

            // A good header wins over ageing in the cycle it completes.
            if (w_hdr_done && !w_hdr_err) begin
                r_fresh <= 1'b1;
            end else if (!bus.en || w_chk_byte || (w_gap_tick && (w_gap_inc > GAP_LIMIT))) begin
                r_fresh <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_hdr_byte && (r_idx < HDR_LAST)) begin
            r_hbuf[r_idx[1:0]] <= w_byte;
        end
        if (w_data_start) begin
            r_chk <= '0;
        end else if (w_data_byte) begin
            r_chk <= r_chk ^ w_byte;
        end
    end

    assign bus.hdr_valid  = r_hdr_valid_p1;
    assign bus.hdr_err    = r_hdr_err_p1;
    assign bus.hdr_sector = r_hdr_sector_p1;
    assign bus.hdr_track  = r_hdr_track_p1;
    assign bus.hdr_id     = r_hdr_id_p1;
    assign bus.data_we    = r_data_we_p1;
    assign bus.data_addr  = r_data_addr_p1;
    assign bus.data_do    = r_data_do_p1;
    assign bus.data_done  = r_data_done_p1;
    assign bus.data_err   = r_data_err_p1;
    assign bus.test_seen  = r_test_seen_p1;
    assign bus.abort      = r_abort_p1;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_ieeedrv_trkparse.sv
// Randomized bench for ieeedrv_trkparse: a transaction-level model predicts
// headers, data writes, checksum/freshness verdicts, test and abort pulses.
module tb_ieeedrv_trkparse;
    import ieeedrv_pkg::*;

    localparam int DATA_LEN = 256;
    localparam int MAX_GAP  = 48;

    logic clk_sys;
    logic reset_n;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    ieeedrv_trkparse_if bus ();

    ieeedrv_trkparse #(.DATA_LEN(DATA_LEN), .MAX_GAP(MAX_GAP)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic        err;
        logic [7:0]  sec;
        logic [7:0]  trk;
        logic [15:0] id;
    } hdr_ev_t;

    hdr_ev_t     hq[$];
    logic [15:0] wq[$];
    logic        dq[$];
    int          n_test = 0;
    int          n_abort = 0;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (bus.hdr_valid) hq.push_back({bus.hdr_err, bus.hdr_sector, bus.hdr_track, bus.hdr_id});
            if (bus.data_we)   wq.push_back({bus.data_addr, bus.data_do});
            if (bus.data_done) dq.push_back(bus.data_err);
            if (bus.test_seen) n_test++;
            if (bus.abort)     n_abort++;
        end
    end

    // Freshness of the last good header, tracked by strobe counting.
    bit         m_fresh;
    int         m_gap;
    logic [7:0] dbuf [DATA_LEN];

    function automatic void m_age(input int n);
        for (int i = 0; i < n; i++) begin
            if (m_fresh) begin
                m_gap++;
                if (m_gap > MAX_GAP) m_fresh = 1'b0;
            end
        end
    endfunction

    function automatic logic [7:0] dbuf_xor(input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) x = x ^ dbuf[i];
        return x;
    endfunction

    function automatic int rlo();
        return int'($urandom_range(1, 3));
    endfunction

    task automatic settle();
        repeat (2) @(negedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int lo);
        @(negedge clk_sys);
        bus.byte_rd = b;
        bus.brdy_n  = 1'b0;
        repeat (lo) @(negedge clk_sys);
        bus.brdy_n  = 1'b1;
    endtask

    task automatic send_sync();
        @(negedge clk_sys);
        bus.sync_rd_n = 1'b0;
        repeat ($urandom_range(2, 5)) @(negedge clk_sys);
        bus.sync_rd_n = 1'b1;
    endtask

    task automatic send_gap(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom), rlo());
        m_age(n);
    endtask

    task automatic send_header(input logic [7:0] ck, input logic [7:0] sec, input logic [7:0] trk,
                               input logic [7:0] ih, input logic [7:0] il);
        logic exp_err;
        send_sync();
        send_byte(HEADER_SYNC_CODE, 1);
        send_byte(ck, rlo());
        send_byte(sec, rlo());
        send_byte(trk, rlo());
        send_byte(ih, rlo());
        send_byte(il, rlo());
        m_age(HDR_LEN + 1);
        exp_err = (ck != (sec ^ trk ^ ih ^ il));
        m_gap = 0;
        if (!exp_err) m_fresh = 1'b1;
        settle();
        check_eq("hdr_cnt", 32'(hq.size()), 32'd1);
        if (hq.size() > 0) begin
            check_eq("hdr_err", 32'(hq[0].err), 32'(exp_err));
            check_eq("hdr_sector", 32'(hq[0].sec), 32'(sec));
            check_eq("hdr_track", 32'(hq[0].trk), 32'(trk));
            check_eq("hdr_id", 32'(hq[0].id), 32'({ih, il}));
        end
        hq.delete();
    endtask

    task automatic send_data(input int n, input logic [7:0] ck, input int lo0);
        logic exp_err;
        send_sync();
        send_byte(DATA_SYNC_CODE, 1);
        m_age(1);
        wq.delete();
        dq.delete();
        for (int i = 0; i < n; i++) send_byte(dbuf[i], (i == 0) ? lo0 : rlo());
        if (n == DATA_LEN) begin
            send_byte(ck, rlo());
            exp_err = (ck != dbuf_xor(n)) || !m_fresh;
            m_fresh = 1'b0;
            settle();
            check_eq("wr_cnt", 32'(wq.size()), 32'(n));
            for (int i = 0; i < wq.size() && i < n; i++)
                check_eq("wr", 32'(wq[i]), 32'({8'(i), dbuf[i]}));
            check_eq("done_cnt", 32'(dq.size()), 32'd1);
            if (dq.size() > 0) check_eq("data_err", 32'(dq[0]), 32'(exp_err));
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_pulses"}, 32'({bus.hdr_valid, bus.hdr_err, bus.data_we, bus.data_done,
                                        bus.data_err, bus.test_seen, bus.abort}), 32'h0);
        check_eq({tag, "_hdr"}, {bus.hdr_sector, bus.hdr_track, bus.hdr_id}, 32'h0);
        check_eq({tag, "_data"}, 32'({bus.data_addr, bus.data_do}), 32'h0);
        check_eq({tag, "_state"}, 32'(bus.state), 32'(P_IDLE));
    endtask

    task automatic fill_random();
        for (int i = 0; i < DATA_LEN; i++) dbuf[i] = 8'($urandom);
    endtask

    initial begin
        int a0;
        int t0;
        logic [7:0] s, t, ih, il, c;

        reset_n       = 1'b0;
        bus.en        = 1'b1;
        bus.sync_rd_n = 1'b1;
        bus.brdy_n    = 1'b1;
        bus.byte_rd   = 8'h00;
        m_fresh       = 1'b0;
        m_gap         = 0;
        #12;
        check_zero("por");
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;

        // Known header, then a counting data block with a held-low first strobe.
        send_header(8'h11, 8'h03, 8'h11, 8'h41, 8'h42);
        send_gap(9);
        for (int i = 0; i < DATA_LEN; i++) dbuf[i] = 8'(i);
        send_data(DATA_LEN, 8'h00, 5);

        // Bad header checksum, then a block with a correct data checksum.
        send_header(8'h12, 8'h03, 8'h11, 8'h41, 8'h42);
        send_data(DATA_LEN, 8'h00, 1);

        // Sync cutting into a data block after 100 bytes.
        send_header(8'h5C ^ 8'h07 ^ 8'hA0 ^ 8'h0B, 8'h5C, 8'h07, 8'hA0, 8'h0B);
        fill_random();
        send_data(100, 8'h00, 1);
        a0 = n_abort;
        @(negedge clk_sys);
        bus.sync_rd_n = 1'b0;
        @(negedge clk_sys);
        #1;
        check_eq("cut_state", 32'(bus.state), 32'(P_SYNC));
        check_eq("cut_abort", 32'(n_abort - a0), 32'd1);
        check_eq("cut_wr_cnt", 32'(wq.size()), 32'd100);
        if (wq.size() == 100) check_eq("cut_last", 32'(wq[99]), 32'({8'd99, dbuf[99]}));
        repeat (2) @(negedge clk_sys);
        #1;
        check_eq("cut_done", 32'(dq.size()), 32'd0);
        fill_random();
        send_data(DATA_LEN, dbuf_xor(DATA_LEN), 1);

        // Test code and an unknown code.
        t0 = n_test;
        a0 = n_abort;
        send_sync();
        send_byte(TEST_SYNC_CODE, 1);
        m_age(1);
        settle();
        check_eq("test_seen", 32'(n_test - t0), 32'd1);
        check_eq("test_abort", 32'(n_abort - a0), 32'd0);
        check_eq("test_state", 32'(bus.state), 32'(P_IDLE));
        t0 = n_test;
        a0 = n_abort;
        send_sync();
        send_byte(8'h55, 1);
        m_age(1);
        settle();
        check_eq("unk_abort", 32'(n_abort - a0), 32'd1);
        check_eq("unk_test", 32'(n_test - t0), 32'd0);
        check_eq("unk_hdr", 32'(hq.size()), 32'd0);

        // Staleness: too many strobes, then just within the window.
        send_header(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04, 8'h01, 8'h02, 8'h03, 8'h04);
        send_gap(49);
        fill_random();
        send_data(DATA_LEN, dbuf_xor(DATA_LEN), 1);
        send_header(8'h09 ^ 8'h22 ^ 8'h30 ^ 8'h44, 8'h09, 8'h22, 8'h30, 8'h44);
        send_gap(47);
        fill_random();
        send_data(DATA_LEN, dbuf_xor(DATA_LEN), 1);

        // Enable dropped mid-header after a good header.
        send_header(8'h10 ^ 8'h20 ^ 8'h30 ^ 8'h40, 8'h10, 8'h20, 8'h30, 8'h40);
        send_sync();
        send_byte(HEADER_SYNC_CODE, 1);
        send_byte(8'h77, 1);
        send_byte(8'h01, 2);
        m_age(3);
        a0 = n_abort;
        @(negedge clk_sys);
        bus.en = 1'b0;
        @(negedge clk_sys);
        #1;
        check_eq("en_state", 32'(bus.state), 32'(P_IDLE));
        check_eq("en_abort", 32'(n_abort - a0), 32'd1);
        bus.en  = 1'b1;
        m_fresh = 1'b0;
        settle();
        check_eq("en_hdr", 32'(hq.size()), 32'd0);
        fill_random();
        send_data(DATA_LEN, dbuf_xor(DATA_LEN), 1);

        // Asynchronous reset in the middle of a data block.
        send_header(8'h21 ^ 8'h05 ^ 8'hDE ^ 8'hAD, 8'h21, 8'h05, 8'hDE, 8'hAD);
        fill_random();
        send_data(50, 8'h00, 1);
        settle();
        check_eq("pre_rst_sector", 32'(bus.hdr_sector), 32'h21);
        check_eq("pre_rst_addr", 32'(bus.data_addr), 32'd49);
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        check_zero("arst");
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        m_fresh = 1'b0;
        m_gap   = 0;
        hq.delete();
        wq.delete();
        dq.delete();
        send_gap(2);
        fill_random();
        send_data(DATA_LEN, dbuf_xor(DATA_LEN), 1);

        // Randomized headers, gaps and blocks.
        for (int k = 0; k < 5; k++) begin
            s  = 8'($urandom);
            t  = 8'($urandom);
            ih = 8'($urandom);
            il = 8'($urandom);
            c  = s ^ t ^ ih ^ il;
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            send_header(c, s, t, ih, il);
            send_gap(int'($urandom_range(0, 60)));
            fill_random();
            c = dbuf_xor(DATA_LEN);
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            send_data(DATA_LEN, c, int'($urandom_range(1, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
